// File: rtl/window_std_dev_seq.sv
// Sequenced window standard deviation: four corner reads, one shared multiplier, iterative sqrt.
// Optional build macro WIN_STD_DEV_CLAMP_EN: a negative variance yields 0 and skips the sqrt.
module window_std_dev_seq #(
  parameter int WIN   = 24,
  parameter int IMG_W = 320,
  parameter int IMG_H = 240,
  parameter int AW    = 17
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [8:0]    in_row,
  input  logic [8:0]    in_col,
  output logic          rd_en,
  output logic [AW-1:0] rd_addr,
  input  logic [31:0]   rd_int,
  input  logic [31:0]   rd_sq,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [31:0]   out_std_dev,
  output logic          busy
);

  localparam logic [31:0]   N_SCALE   = 32'(WIN * WIN);
  localparam logic [AW-1:0] ROW_PITCH = AW'(IMG_W + 1);
  localparam logic [AW-1:0] WIN_A     = AW'(WIN);

  if ((IMG_H + 1) * (IMG_W + 1) > (1 << AW)) begin : g_aw_check
    $error("AW cannot address the whole integral image");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_DRAIN,
    S_MUL_A,
    S_MUL_B,
    S_SUB,
    S_SQRT,
    S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [8:0]  row_q, row_d;
  logic [8:0]  col_q, col_d;
  logic        rd_vld_q, rd_vld_d;
  logic [1:0]  rd_sel_q, rd_sel_d;
  logic [31:0] sum_q, sum_d;
  logic [31:0] sq_sum_q, sq_sum_d;
  logic [31:0] prod_a_q, prod_a_d;
  logic [31:0] prod_b_q, prod_b_d;
  logic [31:0] rad_q, rad_d;
  logic [17:0] rem_q, rem_d;
  logic [15:0] root_q, root_d;

  // Shared multiplier: only the low 32 bits of the product are ever kept.
  logic [31:0] mul_x, mul_y, mul_p;
  assign mul_p = mul_x * mul_y;

  logic [31:0] var_w;
  assign var_w = prod_a_q - prod_b_q;

  // One restoring sqrt step: bring down two radicand bits, try subtracting 4*root+1.
  logic [19:0] rem_sh;
  logic [17:0] trial;
  logic        take;
  assign rem_sh = {rem_q, rad_q[31:30]};
  assign trial  = {root_q, 2'b01};
  assign take   = (rem_sh >= {2'b00, trial});

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
    state_d  = state_q;
    cnt_d    = cnt_q;
    row_d    = row_q;
    col_d    = col_q;
    sum_d    = sum_q;
    sq_sum_d = sq_sum_q;
    prod_a_d = prod_a_q;
    prod_b_d = prod_b_q;
    rad_d    = rad_q;
    rem_d    = rem_q;
    root_d   = root_q;
    rd_vld_d = (state_q == S_READ);
    rd_sel_d = cnt_q[1:0];
    mul_x    = sq_sum_q;
    mul_y    = N_SCALE;

    if (state_q == S_MUL_B) begin
      mul_x = sum_q;
      mul_y = sum_q;
    end

    // Corner returns arrive one cycle after each strobe; TL and BR add, TR and BL subtract.
    if (rd_vld_q) begin
      if (rd_sel_q[0] == rd_sel_q[1]) begin
        sum_d    = sum_q + rd_int;
        sq_sum_d = sq_sum_q + rd_sq;
      end else begin
        sum_d    = sum_q - rd_int;
        sq_sum_d = sq_sum_q - rd_sq;
      end
    end

    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          row_d    = in_row;
          col_d    = in_col;
          sum_d    = '0;
          sq_sum_d = '0;
          root_d   = '0;
          cnt_d    = '0;
          state_d  = S_READ;
        end
      end
      S_READ: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd3) state_d = S_DRAIN;
      end
      S_DRAIN: state_d = S_MUL_A;
      S_MUL_A: begin
        prod_a_d = mul_p;
        state_d  = S_MUL_B;
      end
      S_MUL_B: begin
        prod_b_d = mul_p;
        state_d  = S_SUB;
      end
      S_SUB: begin
        rad_d   = var_w;
        rem_d   = '0;
        root_d  = '0;
        cnt_d   = '0;
        state_d = S_SQRT;
`ifdef WIN_STD_DEV_CLAMP_EN
        if (var_w[31]) begin
          rad_d   = '0;
          state_d = S_DONE;
        end
`endif
      end
      S_SQRT: begin
        rad_d = {rad_q[29:0], 2'b00};
        if (take) begin
          rem_d  = rem_sh[17:0] - trial;
          root_d = {root_q[14:0], 1'b1};
        end else begin
          rem_d  = rem_sh[17:0];
          root_d = {root_q[14:0], 1'b0};
        end
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd15) state_d = S_DONE;
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      row_q    <= '0;
      col_q    <= '0;
      rd_vld_q <= 1'b0;
      rd_sel_q <= '0;
      sum_q    <= '0;
      sq_sum_q <= '0;
      prod_a_q <= '0;
      prod_b_q <= '0;
      rad_q    <= '0;
      rem_q    <= '0;
      root_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      row_q    <= row_d;
      col_q    <= col_d;
      rd_vld_q <= rd_vld_d;
      rd_sel_q <= rd_sel_d;
      sum_q    <= sum_d;
      sq_sum_q <= sq_sum_d;
      prod_a_q <= prod_a_d;
      prod_b_q <= prod_b_d;
      rad_q    <= rad_d;
      rem_q    <= rem_d;
      root_q   <= root_d;
    end
  end

  // Corner order by cnt_q: bit 0 steps the column by WIN, bit 1 steps the row by WIN.
  logic [AW-1:0] row_a, col_a;
  always_comb begin
    row_a   = AW'(row_q) + (cnt_q[1] ? WIN_A : '0);
    col_a   = AW'(col_q) + (cnt_q[0] ? WIN_A : '0);
    rd_addr = '0;
    if (state_q == S_READ) rd_addr = row_a * ROW_PITCH + col_a;
  end

  assign in_ready    = (state_q == S_IDLE);
  assign busy        = (state_q != S_IDLE);
  assign rd_en       = (state_q == S_READ);
  assign out_valid   = (state_q == S_DONE);
  assign out_std_dev = {16'h0000, root_q};

endmodule

// File: tb/tb_window_std_dev_seq.sv
// Self-checking bench for window_std_dev_seq: pixel-level reference model, per-cycle output checks.
module tb_window_std_dev_seq;

  localparam int WIN   = 24;
  localparam int IMG_W = 320;
  localparam int IMG_H = 240;
  localparam int AW    = 17;
  localparam int PITCH = IMG_W + 1;
  localparam logic [31:0] N_SCALE = 32'(WIN * WIN);

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic [8:0]    in_row = '0;
  logic [8:0]    in_col = '0;
  logic [31:0]   rd_int = '0;
  logic [31:0]   rd_sq = '0;
  logic          in_ready, rd_en, out_valid, busy;
  logic [AW-1:0] rd_addr;
  logic [31:0]   out_std_dev;

  window_std_dev_seq #(.WIN(WIN), .IMG_W(IMG_W), .IMG_H(IMG_H), .AW(AW)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_row     (in_row),
    .in_col     (in_col),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .rd_int     (rd_int),
    .rd_sq      (rd_sq),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_std_dev(out_std_dev),
    .busy       (busy)
  );

  always #5 clock = ~clock;

  logic [31:0] mem_int [0:(1<<AW)-1];
  logic [31:0] mem_sq  [0:(1<<AW)-1];
  logic [7:0]  pix [IMG_H][IMG_W];

  // Read port: data for a strobe is presented in the following cycle.
  always @(posedge clock) begin
    if (rd_en) begin
      rd_int <= mem_int[rd_addr];
      rd_sq  <= mem_sq[rd_addr];
    end
  end

  int vectors = 0;
  int miscompares = 0;

  bit          use_pix;
  logic [31:0] exp_std;
  int          exp_lat;
  int          exp_row, exp_col;
  bit          job_active = 1'b0;
  int          job_cyc, first_valid, last_lat, jobs_done = 0;
  logic [31:0] last_std;
  logic [AW-1:0] rd_log [4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0d (0x%08h), expected %0d (0x%08h) at %0t", name, act, act, req, req, $time);
    end
  endtask

  function automatic logic [AW-1:0] corner_addr(input int r, input int c, input int k);
    return AW'((r + ((k >= 2) ? WIN : 0)) * PITCH + c + ((k % 2 == 1) ? WIN : 0));
  endfunction

  function automatic logic [31:0] isqrt(input logic [31:0] v);
    longint lo = 0, hi = 65536, mid;
    while (hi - lo > 1) begin
      mid = (lo + hi) / 2;
      if (mid * mid <= longint'(v)) lo = mid;
      else hi = mid;
    end
    return 32'(lo);
  endfunction

  // Reference: variance = N*sq_sum - sum^2 in 32-bit wraparound arithmetic, then floor sqrt.
  task automatic model(input logic [31:0] s, input logic [31:0] q, output logic [31:0] std, output int lat);
    logic [31:0] v;
    v = N_SCALE * q - s * s;
    std = isqrt(v);
    lat = 25;
`ifdef WIN_STD_DEV_CLAMP_EN
    if ($signed(v) < 0) begin
      std = '0;
      lat = 9;
    end
`endif
  endtask

  task automatic window_sums(input int r, input int c, output logic [31:0] s, output logic [31:0] q);
    logic [31:0] a [4];
    logic [31:0] b [4];
    s = '0;
    q = '0;
    if (use_pix) begin
      for (int i = 0; i < WIN; i++)
        for (int j = 0; j < WIN; j++) begin
          s += {24'h0, pix[r+i][c+j]};
          q += {24'h0, pix[r+i][c+j]} * {24'h0, pix[r+i][c+j]};
        end
    end else begin
      for (int k = 0; k < 4; k++) begin
        a[k] = mem_int[corner_addr(r, c, k)];
        b[k] = mem_sq[corner_addr(r, c, k)];
      end
      s = a[0] - a[1] - a[2] + a[3];
      q = b[0] - b[1] - b[2] + b[3];
    end
  endtask

  // mode 0: constant 5; mode 1: alternating 0/2 columns; mode 2: random bytes.
  task automatic load_image(input int mode);
    int idx;
    logic [31:0] p;
    for (int r = 0; r < IMG_H; r++)
      for (int c = 0; c < IMG_W; c++)
        pix[r][c] = (mode == 0) ? 8'd5 : (mode == 1) ? ((c % 2 == 1) ? 8'd2 : 8'd0)
                                                      : 8'($urandom_range(0, 255));
    for (int r = 0; r <= IMG_H; r++)
      for (int c = 0; c <= IMG_W; c++) begin
        idx = r * PITCH + c;
        if (r == 0 || c == 0) begin
          mem_int[idx] = '0;
          mem_sq[idx]  = '0;
        end else begin
          p = {24'h0, pix[r-1][c-1]};
          mem_int[idx] = p + mem_int[idx-PITCH] + mem_int[idx-1] - mem_int[idx-PITCH-1];
          mem_sq[idx]  = p * p + mem_sq[idx-PITCH] + mem_sq[idx-1] - mem_sq[idx-PITCH-1];
        end
      end
    use_pix = 1'b1;
  endtask

  // Single compare process: every cycle after the falling edge.
  always @(negedge clock) begin
    if (!reset_n) begin
      check("rst_rd_en", 32'(rd_en), 0);
      check("rst_rd_addr", 32'(rd_addr), 0);
      check("rst_out_valid", 32'(out_valid), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_out_std_dev", out_std_dev, 0);
      job_active = 1'b0;
    end else if (job_active) begin
      job_cyc++;
      check("rd_en", 32'(rd_en), 32'(job_cyc >= 1 && job_cyc <= 4));
      if (job_cyc >= 1 && job_cyc <= 4) begin
        rd_log[job_cyc-1] = rd_addr;
        check("rd_addr", 32'(rd_addr), 32'(corner_addr(exp_row, exp_col, job_cyc - 1)));
      end
      check("busy", 32'(busy), 1);
      check("in_ready_busy", 32'(in_ready), 0);
      check("out_valid", 32'(out_valid), 32'(job_cyc >= exp_lat));
      if (out_valid) begin
        check("out_std_dev", out_std_dev, exp_std);
        if (first_valid < 0) first_valid = job_cyc;
        if (out_ready) begin
          last_std   = out_std_dev;
          last_lat   = first_valid;
          job_active = 1'b0;
          jobs_done++;
        end
      end
      if (job_cyc > 2000) begin
        check("job_cycle_budget", 32'(job_cyc), 2000);
        job_active = 1'b0;
      end
    end else begin
      check("idle_in_ready", 32'(in_ready), 1);
      check("idle_busy", 32'(busy), 0);
      check("idle_out_valid", 32'(out_valid), 0);
      check("idle_rd_en", 32'(rd_en), 0);
      if (in_valid) begin
        job_active  = 1'b1;
        job_cyc     = 0;
        first_valid = -1;
      end
    end
  end

  task automatic start_job(input int r, input int c, input bit hold);
    int guard = 0;
    logic [31:0] s, q;
    do begin
      @(posedge clock); #1;
      guard++;
    end while (!in_ready && guard < 100);
    if (!in_ready) check("in_ready_timeout", 32'(in_ready), 1);
    window_sums(r, c, s, q);
    model(s, q, exp_std, exp_lat);
    exp_row   = r;
    exp_col   = c;
    in_row    = 9'(r);
    in_col    = 9'(c);
    out_ready = !hold;
    in_valid  = 1'b1;
    @(posedge clock); #1;
    in_valid  = 1'b0;
  endtask

  task automatic finish_job(input int stall);
    int guard = 0;
    if (stall > 0) begin
      while (!out_valid && guard < 100) begin
        @(posedge clock); #1;
        guard++;
      end
      if (!out_valid) check("out_valid_timeout", 32'(out_valid), 1);
      for (int i = 0; i < stall; i++) begin
        in_valid = (i % 2 == 0);
        @(posedge clock); #1;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
    end
    guard = 0;
    while (job_active && guard < 200) begin
      @(posedge clock); #1;
      guard++;
    end
    if (job_active) check("job_done_timeout", 32'(job_active), 0);
  endtask

  task automatic run_job(input int r, input int c, input int stall);
    start_job(r, c, stall > 0);
    finish_job(stall);
  endtask

  initial begin
    int aborted_at;
    repeat (3) @(posedge clock);
    #1 reset_n = 1'b1;
    check("in_ready_after_reset", 32'(in_ready), 1);

    // Constant image: zero variance.
    load_image(0);
    run_job(0, 0, 0);
    check("const_model", exp_std, 0);
    check("const_result", last_std, 0);
    check("const_latency", 32'(last_lat), 25);

    // Alternating 0/2 columns: every window has sum 576, sq_sum 1152.
    load_image(1);
    run_job(0, 0, 0);
    check("half_model", exp_std, 576);
    check("half_result", last_std, 576);
    run_job(10, 20, 0);
    check("addr_tl", 32'(rd_log[0]), 3230);
    check("addr_tr", 32'(rd_log[1]), 3254);
    check("addr_bl", 32'(rd_log[2]), 10934);
    check("addr_br", 32'(rd_log[3]), 10958);
    check("half_result_10_20", last_std, 576);

    // Forced corners: sum=100, sq_sum=0 gives a negative 32-bit variance.
    for (int i = 0; i < (1 << AW); i++) begin
      mem_int[i] = '0;
      mem_sq[i]  = '0;
    end
    mem_int[corner_addr(0, 0, 3)] = 32'd100;
    use_pix = 1'b0;
    run_job(0, 0, 0);
`ifdef WIN_STD_DEV_CLAMP_EN
    check("forced_result", last_std, 0);
    check("forced_latency", 32'(last_lat), 9);
`else
    check("forced_result", last_std, 65535);
    check("forced_latency", 32'(last_lat), 25);
`endif

    // Long output stall with in_valid pulses that must be ignored.
    load_image(2);
    run_job(100, 150, 10);
    check("stall_result", last_std, exp_std);

    // Reset while the job is deep in its computation; no result may appear.
    start_job(5, 7, 1'b1);
    aborted_at = jobs_done;
    repeat (12) @(posedge clock);
    #1 reset_n = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    out_ready = 1'b1;
    check("abort_no_result", 32'(jobs_done), 32'(aborted_at));
    check("in_ready_after_abort", 32'(in_ready), 1);
    run_job(5, 7, 0);
    check("post_reset_result", last_std, exp_std);

    // Random windows on random images.
    for (int n = 0; n < 15; n++)
      run_job($urandom_range(0, IMG_H - WIN), $urandom_range(0, IMG_W - WIN), $urandom_range(0, 3));
    run_job(IMG_H - WIN, IMG_W - WIN, 0);

    // Raw random table words exercise the wraparound and sign cases.
    for (int i = 0; i < (1 << AW); i++) begin
      mem_int[i] = $urandom;
      mem_sq[i]  = $urandom;
    end
    use_pix = 1'b0;
    for (int n = 0; n < 12; n++)
      run_job($urandom_range(0, IMG_H - WIN), $urandom_range(0, IMG_W - WIN), $urandom_range(0, 3));

    repeat (3) @(posedge clock);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
